// File: rtl/sd_window_scheduler.sv
// Shares one density accumulator across N_CH sigma-delta bitstreams,
// publishing one {channel, ones-count} result per enabled channel per pass.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   sd_bs[N_CH]     bitstreams, bit i = channel i
//   ch_en[N_CH]     enable mask, latched at the start of each pass
//   start           begins a pass from IDLE
//   continuous      sampled at pass end, 1 = chain straight into a new pass
//   stop            abort to IDLE, drops any pending result
//   res_valid/ready result handshake, res_data = count, res_ch = channel
//   busy            high whenever not IDLE
//   pass_done       one-cycle pulse after the last result of a pass transfers
module sd_window_scheduler #(
    parameter int N_CH   = 4,
    parameter int PERIOD = 60,
    parameter int WIDTH  = 6,
    parameter int SETTLE = 2,
    localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  sd_bs,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [CHW-1:0]   res_ch,
    output logic             busy,
    output logic             pass_done
);

    localparam int CNT_MAX  = (PERIOD > SETTLE) ? PERIOD : SETTLE;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int SET_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_PUBLISH
    } state_t;

    // Every channel window is entered through this state.
    localparam state_t FIRST = (SETTLE == 0) ? S_ACCUM : S_SETTLE;

    state_t           state_q, state_d;
    logic [N_CH-1:0]  mask_q;
    logic [CHW-1:0]   ch_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] data_q;
    logic [CHW-1:0]   rch_q;
    logic             valid_q;
    logic             done_q;

    logic [CHW-1:0]   lo_ch, hi_ch;
    logic             lo_found, hi_found;
    logic             bit_in;
    logic             set_last, per_last;

    assign bit_in   = sd_bs[ch_q];
    assign set_last = (cnt_q == CW'(SET_LAST));
    assign per_last = (cnt_q == CW'(PERIOD - 1));

    // lo_*: lowest bit of the live ch_en (pass start).
    // hi_*: next latched channel above the current one.
    always_comb begin
        lo_ch    = '0;
        lo_found = 1'b0;
        hi_ch    = '0;
        hi_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                lo_ch    = CHW'(i);
                lo_found = 1'b1;
            end
            if (mask_q[i] && (CHW'(i) > ch_q)) begin
                hi_ch    = CHW'(i);
                hi_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (start && lo_found) state_d = FIRST;
            S_SETTLE:
                if (set_last) state_d = S_ACCUM;
            S_ACCUM:
                if (per_last) state_d = S_PUBLISH;
            S_PUBLISH:
                if (res_ready) begin
                    if (hi_found)
                        state_d = FIRST;
                    else if (continuous && lo_found)
                        state_d = FIRST;
                    else
                        state_d = S_IDLE;
                end
            default:
                state_d = S_IDLE;
        endcase
        if (stop) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            rch_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE:
                        if (start && lo_found) begin
                            mask_q <= ch_en;
                            ch_q   <= lo_ch;
                            cnt_q  <= '0;
                            sum_q  <= '0;
                        end
                    S_SETTLE:
                        cnt_q <= set_last ? '0 : cnt_q + CW'(1);
                    S_ACCUM:
                        if (per_last) begin
                            data_q  <= sum_q + WIDTH'(bit_in);
                            rch_q   <= ch_q;
                            valid_q <= 1'b1;
                            sum_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            sum_q <= sum_q + WIDTH'(bit_in);
                            cnt_q <= cnt_q + CW'(1);
                        end
                    S_PUBLISH:
                        if (res_ready) begin
                            valid_q <= 1'b0;
                            if (hi_found) begin
                                ch_q <= hi_ch;
                            end else begin
                                done_q <= 1'b1;
                                if (continuous && lo_found) begin
                                    mask_q <= ch_en;
                                    ch_q   <= lo_ch;
                                end
                            end
                        end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        res_valid = valid_q;
        res_data  = data_q;
        res_ch    = rch_q;
        pass_done = done_q;
    end

endmodule

// File: tb/tb_sd_window_scheduler.sv
// Directed bench for sd_window_scheduler at N_CH=4, PERIOD=60, SETTLE=2.
// sd_bs pattern: bit0 = 1, bit1 = 0, bit2 toggles, bit3 high 1 clock in 4.
module tb_sd_window_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sd_bs;
    logic [3:0] ch_en;
    logic       start;
    logic       continuous;
    logic       stop;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_data;
    logic [1:0] res_ch;
    logic       busy;
    logic       pass_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n;
    logic seen;

    sd_window_scheduler #(
        .N_CH(4), .PERIOD(60), .WIDTH(6), .SETTLE(2)
    ) dut (
        .clk(clk), .rst(rst), .sd_bs(sd_bs), .ch_en(ch_en),
        .start(start), .continuous(continuous), .stop(stop),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ch(res_ch),
        .busy(busy), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sd_bs = {(cyc % 4) == 0, cyc[0], 1'b0, 1'b1};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!res_valid && cnt < 200);
    endtask

    initial begin
        rst = 1'b1; sd_bs = 4'b0001; ch_en = 4'b0000;
        start = 1'b0; continuous = 1'b0; stop = 1'b0;
        res_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_data",  32'(res_data), 0);
        chk("rst_ch",    32'(res_ch), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(pass_done), 0);
        rst = 1'b0;
        tick();

        // Two-channel pass, consumer always ready.
        ch_en = 4'b0101;
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        wait_valid(n);
        chk("t1_lat0", n, 62);
        chk("t1_ch0",  32'(res_ch), 0);
        chk("t1_d0",   32'(res_data), 60);
        tick();
        chk("t1_xfer_valid", 32'(res_valid), 0);
        chk("t1_mid_done",   32'(pass_done), 0);
        chk("t1_mid_busy",   32'(busy), 1);
        wait_valid(n);
        chk("t1_lat2", n, 62);
        chk("t1_ch2",  32'(res_ch), 2);
        chk("t1_d2",   32'(res_data), 30);
        tick();
        chk("t1_done", 32'(pass_done), 1);
        chk("t1_idle", 32'(busy), 0);
        tick();
        chk("t1_done_clr", 32'(pass_done), 0);

        // Backpressure for 20 clocks on the first result.
        res_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        chk("t2_lat0", n, 62);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2_hold_valid", 32'(res_valid), 1);
            chk("t2_hold_data",  32'(res_data), 60);
            chk("t2_hold_ch",    32'(res_ch), 0);
        end
        res_ready = 1'b1;
        tick();
        chk("t2_xfer_valid", 32'(res_valid), 0);
        wait_valid(n);
        chk("t2_lat2", n, 62);
        chk("t2_d2",   32'(res_data), 30);
        tick();
        chk("t2_done", 32'(pass_done), 1);

        // Empty mask: start does nothing.
        ch_en = 4'b0000;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            seen = seen | busy | res_valid | pass_done;
            tick();
        end
        chk("t3_quiet", 32'(seen), 0);

        // Continuous single channel 3.
        continuous = 1'b1;
        ch_en = 4'b1000;
        pulse_start();
        wait_valid(n);
        chk("t4_lat_a", n, 62);
        chk("t4_ch_a",  32'(res_ch), 3);
        chk("t4_d_a",   32'(res_data), 15);
        tick();
        chk("t4_done_a", 32'(pass_done), 1);
        chk("t4_busy_a", 32'(busy), 1);
        wait_valid(n);
        chk("t4_lat_b", n, 62);
        chk("t4_ch_b",  32'(res_ch), 3);
        chk("t4_d_b",   32'(res_data), 15);
        continuous = 1'b0;
        tick();
        chk("t4_done_b", 32'(pass_done), 1);
        chk("t4_busy_b", 32'(busy), 0);

        // Stop 10 samples into the ch0 window.
        ch_en = 4'b0101;
        pulse_start();
        for (int i = 0; i < 12; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_busy",  32'(busy), 0);
        chk("t5_stop_valid", 32'(res_valid), 0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            seen = seen | res_valid | pass_done | busy;
        end
        chk("t5_quiet", 32'(seen), 0);
        pulse_start();
        wait_valid(n);
        chk("t5_lat", n, 62);
        chk("t5_d0",  32'(res_data), 60);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_drop_valid", 32'(res_valid), 0);
        chk("t5_drop_done",  32'(pass_done), 0);

        // Reset while holding a result in PUBLISH.
        res_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        chk("t6_lat", n, 62);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(res_valid), 0);
        chk("t6_data",  32'(res_data), 0);
        chk("t6_ch",    32'(res_ch), 0);
        chk("t6_busy",  32'(busy), 0);
        chk("t6_done",  32'(pass_done), 0);
        res_ready = 1'b1;
        ch_en = 4'b0110;
        pulse_start();
        wait_valid(n);
        chk("t6_lat1", n, 62);
        chk("t6_ch1",  32'(res_ch), 1);
        chk("t6_d1",   32'(res_data), 0);
        tick();
        wait_valid(n);
        chk("t6_lat2", n, 62);
        chk("t6_ch2",  32'(res_ch), 2);
        chk("t6_d2",   32'(res_data), 30);
        tick();
        chk("t6_pass", 32'(pass_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
